vga_sync_receiver: RTL and testbench

// - Sink-side VGA timing decoder: samples H_SYNC/V_SYNC/v_en from the pixel generator on the pixel clock.
// - Recovers pixel coordinates, checks line/frame totals, declares lock; feeds frame-capture and self-check logic.

---
 rtl/vga_sync_receiver.sv | 244 ++++++++++++++++++++++++
 tb/tb_vga_sync_receiver.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_receiver.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync_receiver
// Brief    : Sink-side VGA timing decoder: pixel coordinates, line/frame
//            length checks and lock detection. Optional macro ERR_CNT_EN adds
//            a saturating error-pulse counter port.
// Revision : 1.0
// ============================================================================
module vga_sync_receiver #(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int LOCK_FRAMES = 2,
    parameter bit SYNC_POL    = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        h_sync,
    input  logic        v_sync,
    input  logic        v_en,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        pix_valid,
    output logic        frame_start,
    output logic        locked,
    output logic [10:0] h_total,
    output logic [9:0]  v_total,
    output logic        err_h,
    output logic        err_v
`ifdef ERR_CNT_EN
    ,
    output logic [15:0] err_cnt
`endif
);

    localparam logic [11:0] C_H_TOTAL = 12'(H_TOTAL);
    localparam logic [11:0] C_TO_M1   = 12'(2 * H_TOTAL - 1);
    localparam logic [10:0] C_V_TOTAL = 11'(V_TOTAL);
    localparam logic [7:0]  C_LOCK    = 8'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        hs_s_q, vs_s_q, ven_s_q;
    logic        hs_prev_q, vs_prev_q;
    logic [10:0] hcnt_q, hcnt_d;
    logic [9:0]  vcnt_q, vcnt_d;
    logic [9:0]  xcnt_q, xcnt_d;
    logic [9:0]  ycnt_q, ycnt_d;
    logic        line_act_q, line_act_d;
    logic        frame_err_q, frame_err_d;
    logic [7:0]  match_q, match_d;
    logic [10:0] h_total_q, h_total_d;
    logic [9:0]  v_total_q, v_total_d;
    logic        err_h_d, err_v_d;
    logic [9:0]  x_q, y_q;
    logic        pix_valid_q, frame_start_q, locked_q, err_h_q, err_v_q;

    logic        w_hs_act, w_vs_act, w_hs_edge, w_vs_edge, w_timeout, w_locked;
    logic [11:0] w_line_len;
    logic [10:0] w_frame_len;
    logic [9:0]  w_x_cur, w_y_cur;

    assign w_hs_act  = (hs_s_q == SYNC_POL);
    assign w_vs_act  = (vs_s_q == SYNC_POL);
    assign w_hs_edge = w_hs_act & ~hs_prev_q;
    assign w_vs_edge = w_vs_act & ~vs_prev_q;
    assign w_locked  = (state_q == ST_LOCKED);

    always_comb begin
        hcnt_d      = hcnt_q;
        vcnt_d      = vcnt_q;
        h_total_d   = h_total_q;
        v_total_d   = v_total_q;
        err_h_d     = 1'b0;
        err_v_d     = 1'b0;
        w_timeout   = 1'b0;
        w_line_len  = {1'b0, hcnt_q} + 12'd1;
        w_frame_len = {1'b0, vcnt_q} + {10'd0, w_hs_edge};

        if (w_hs_edge) begin
            hcnt_d    = '0;
            h_total_d = w_line_len[11] ? 11'h7FF : w_line_len[10:0];
            err_h_d   = (state_q != ST_SEARCH) && (w_line_len != C_H_TOTAL);
        end else begin
            if (hcnt_q != 11'h7FF) begin
                hcnt_d = hcnt_q + 11'd1;
            end
            if ({1'b0, hcnt_q} == C_TO_M1) begin
                w_timeout = 1'b1;
                err_h_d   = 1'b1;
            end
        end

        // The closing line is counted into the frame before the frame closes.
        if (w_vs_edge) begin
            vcnt_d    = '0;
            v_total_d = w_frame_len[10] ? 10'h3FF : w_frame_len[9:0];
            err_v_d   = (state_q != ST_SEARCH) && (w_frame_len != C_V_TOTAL);
        end else if (w_hs_edge && (vcnt_q != 10'h3FF)) begin
            vcnt_d = vcnt_q + 10'd1;
        end

        w_x_cur = w_hs_edge ? 10'd0 : xcnt_q;
        xcnt_d  = (ven_s_q && (w_x_cur != 10'h3FF)) ? w_x_cur + 10'd1 : w_x_cur;

        if (w_vs_edge) begin
            w_y_cur = 10'd0;
        end else if (w_hs_edge && line_act_q && (ycnt_q != 10'h3FF)) begin
            w_y_cur = ycnt_q + 10'd1;
        end else begin
            w_y_cur = ycnt_q;
        end
        ycnt_d     = w_y_cur;
        line_act_d = w_hs_edge ? ven_s_q : (line_act_q | ven_s_q);
    end

    always_comb begin
        state_d     = state_q;
        match_d     = match_q;
        frame_err_d = (frame_err_q | err_h_d) & ~w_vs_edge;
        case (state_q)
            ST_SEARCH: begin
                if (w_vs_edge) begin
                    state_d = ST_MEASURE;
                    match_d = '0;
                end
            end
            ST_MEASURE: begin
                if (err_h_d || err_v_d) begin
                    match_d = '0;
                end else if (w_vs_edge && !frame_err_q) begin
                    if (match_q + 8'd1 == C_LOCK) begin
                        state_d = ST_LOCKED;
                        match_d = '0;
                    end else begin
                        match_d = match_q + 8'd1;
                    end
                end
            end
            ST_LOCKED: begin
                if (err_h_d || err_v_d) begin
                    state_d = ST_MEASURE;
                    match_d = '0;
                end
            end
            default: begin
                state_d = ST_SEARCH;
                match_d = '0;
            end
        endcase
        if (w_timeout) begin
            state_d = ST_SEARCH;
            match_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // Sync stages park at the active level so a reset released
            // mid-pulse does not fabricate an edge.
            hs_s_q        <= SYNC_POL;
            vs_s_q        <= SYNC_POL;
            ven_s_q       <= 1'b0;
            hs_prev_q     <= 1'b1;
            vs_prev_q     <= 1'b1;
            state_q       <= ST_SEARCH;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            xcnt_q        <= '0;
            ycnt_q        <= '0;
            line_act_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            match_q       <= '0;
            h_total_q     <= '0;
            v_total_q     <= '0;
            x_q           <= '0;
            y_q           <= '0;
            pix_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
            err_h_q       <= 1'b0;
            err_v_q       <= 1'b0;
        end else begin
            hs_s_q        <= h_sync;
            vs_s_q        <= v_sync;
            ven_s_q       <= v_en;
            hs_prev_q     <= w_hs_act;
            vs_prev_q     <= w_vs_act;
            state_q       <= state_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            xcnt_q        <= xcnt_d;
            ycnt_q        <= ycnt_d;
            line_act_q    <= line_act_d;
            frame_err_q   <= frame_err_d;
            match_q       <= match_d;
            h_total_q     <= h_total_d;
            v_total_q     <= v_total_d;
            x_q           <= w_x_cur;
            y_q           <= w_y_cur;
            pix_valid_q   <= ven_s_q & w_locked;
            frame_start_q <= w_vs_edge;
            locked_q      <= w_locked;
            err_h_q       <= err_h_d;
            err_v_q       <= err_v_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign pix_valid   = pix_valid_q;
    assign frame_start = frame_start_q;
    assign locked      = locked_q;
    assign h_total     = h_total_q;
    assign v_total     = v_total_q;
    assign err_h       = err_h_q;
    assign err_v       = err_v_q;

`ifdef ERR_CNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [16:0] w_err_sum;

    always_comb begin
        w_err_sum = {1'b0, err_cnt_q} + {16'd0, err_h_d} + {16'd0, err_v_d};
        err_cnt_d = w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_sync_receiver
// Brief    : Directed bench for vga_sync_receiver on a reduced 16x10 raster
//            (8x6 visible, active-low syncs).
// Revision : 1.0
// ============================================================================
module tb_vga_sync_receiver;

    localparam int H = 16;
    localparam int V = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        h_sync = 1'b1;
    logic        v_sync = 1'b1;
    logic        v_en = 1'b0;
    logic [9:0]  x, y;
    logic        pix_valid, frame_start, locked, err_h, err_v;
    logic [10:0] h_total;
    logic [9:0]  v_total;
`ifdef ERR_CNT_EN
    logic [15:0] err_cnt;
`endif

    always #5 clk = ~clk;

    vga_sync_receiver #(
        .H_TOTAL(H), .V_TOTAL(V), .LOCK_FRAMES(2), .SYNC_POL(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .h_sync(h_sync), .v_sync(v_sync), .v_en(v_en),
        .x(x), .y(y), .pix_valid(pix_valid), .frame_start(frame_start),
        .locked(locked), .h_total(h_total), .v_total(v_total),
        .err_h(err_h), .err_v(err_v)
`ifdef ERR_CNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    typedef struct {
        int   nframes;
        int   bad_frame;
        int   bad_line_len;
        int   short_lines;
        int   e_errh;
        int   e_errv;
        int   e_fs;
        int   e_pv;
        logic e_locked;
        int   e_ht;
        int   e_vt;
    } vec_t;

    vec_t tbl [5];

    int cyc = 0;
    int vs_cyc = 0;
    int drv_x = 0, drv_y = 0;
    int n_checks = 0, n_pass = 0;

    // Monitor: pulse-cycle counts and pixel coordinates against the
    // stimulus delayed by the two-clock pipeline.
    int   n_errh = 0, n_errv = 0, n_fs = 0, n_pv = 0, n_pixbad = 0, n_latbad = 0;
    int   d1x = 0, d1y = 0, d2x = 0, d2y = 0;
    logic d1v = 1'b0, d2v = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        n_errh <= n_errh + int'(err_h);
        n_errv <= n_errv + int'(err_v);
        n_fs   <= n_fs + int'(frame_start);
        n_pv   <= n_pv + int'(pix_valid);
        if (pix_valid && !(d2v && (int'(x) == d2x) && (int'(y) == d2y)))
            n_pixbad <= n_pixbad + 1;
        if (frame_start && (cyc - vs_cyc != 2))
            n_latbad <= n_latbad + 1;
        d2x <= d1x; d2y <= d1y; d2v <= d1v;
        d1x <= drv_x; d1y <= drv_y; d1v <= v_en;
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic drive_cycle(input logic hs, input logic vs, input logic ven,
                               input int px, input int py);
        @(posedge clk);
        #1;
        if (!vs && v_sync) vs_cyc = cyc;
        h_sync = hs;
        v_sync = vs;
        v_en   = ven;
        drv_x  = px;
        drv_y  = py;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b1, 1'b1, 1'b0, 0, 0);
    endtask

    // Raster: hsync low c0..1, vsync low for line 0, visible c4..11 on lines 2..7.
    task automatic drive_frame(input int nlines, input int bad_line, input int bad_len);
        int len;
        for (int l = 0; l < nlines; l++) begin
            len = (l == bad_line) ? bad_len : H;
            for (int c = 0; c < len; c++)
                drive_cycle((c < 2) ? 1'b0 : 1'b1, (l == 0) ? 1'b0 : 1'b1,
                            (l >= 2 && l < 8 && c >= 4 && c < 12), c - 4, l - 2);
        end
    endtask

    int s_errh, s_errv, s_fs, s_pv, s_pix;

    task automatic snap();
        s_errh = n_errh; s_errv = n_errv; s_fs = n_fs; s_pv = n_pv; s_pix = n_pixbad;
    endtask

    initial begin
        tbl[0] = '{4, -1, 0,  0, 0, 0, 4, 96, 1'b1, 16, 10};
        tbl[1] = '{3,  0, 15, 0, 1, 0, 3, 32, 1'b0, 16, 10};
        tbl[2] = '{2, -1, 0,  0, 0, 0, 2, 96, 1'b1, 16, 10};
        tbl[3] = '{2,  0, 0,  9, 0, 1, 2, 48, 1'b0, 16, 9};
        tbl[4] = '{3, -1, 0,  0, 0, 0, 3, 96, 1'b1, 16, 10};

        rst_n = 1'b0;
        idle(3);
        check("reset_outputs", {x, y, pix_valid, frame_start, locked, h_total, v_total, err_h, err_v}, 0);
        rst_n = 1'b1;
        idle(4);

        for (int i = 0; i < 5; i++) begin
            snap();
            for (int f = 0; f < tbl[i].nframes; f++) begin
                drive_frame((f == tbl[i].bad_frame && tbl[i].short_lines > 0) ? tbl[i].short_lines : V,
                            (f == tbl[i].bad_frame && tbl[i].bad_line_len > 0) ? 5 : -1,
                            tbl[i].bad_line_len);
            end
            check($sformatf("v%0d_err_h", i), n_errh - s_errh, tbl[i].e_errh);
            check($sformatf("v%0d_err_v", i), n_errv - s_errv, tbl[i].e_errv);
            check($sformatf("v%0d_frame_start", i), n_fs - s_fs, tbl[i].e_fs);
            check($sformatf("v%0d_pix_valid", i), n_pv - s_pv, tbl[i].e_pv);
            check($sformatf("v%0d_locked", i), locked, tbl[i].e_locked);
            check($sformatf("v%0d_h_total", i), h_total, tbl[i].e_ht);
            check($sformatf("v%0d_v_total", i), v_total, tbl[i].e_vt);
            check($sformatf("v%0d_pix_xy", i), n_pixbad - s_pix, 0);
        end

        // hsync stalls: one timeout pulse, lock lost, no frame_start until vsync.
        snap();
        idle(40);
        check("timeout_err_h", n_errh - s_errh, 1);
        check("timeout_frame_start", n_fs - s_fs, 0);
        check("timeout_locked", locked, 0);

        snap();
        for (int f = 0; f < 3; f++) drive_frame(V, -1, 0);
        check("relock_err_h", n_errh - s_errh, 0);
        check("relock_frame_start", n_fs - s_fs, 3);
        check("relock_locked", locked, 1);
        check("relock_pix_valid", n_pv - s_pv, 48);
`ifdef ERR_CNT_EN
        check("err_cnt_total", err_cnt, 3);
`endif

        // Reset in the middle of a frame.
        drive_frame(5, -1, 0);
        rst_n = 1'b0;
        idle(1);
        check("midreset_outputs", {x, y, pix_valid, frame_start, locked, h_total, v_total, err_h, err_v}, 0);
`ifdef ERR_CNT_EN
        check("midreset_err_cnt", err_cnt, 0);
`endif
        idle(2);
        rst_n = 1'b1;
        idle(4);
        snap();
        for (int f = 0; f < 4; f++) drive_frame(V, -1, 0);
        check("postreset_err", (n_errh - s_errh) + (n_errv - s_errv), 0);
        check("postreset_frame_start", n_fs - s_fs, 4);
        check("postreset_locked", locked, 1);
        check("postreset_pix_valid", n_pv - s_pv, 96);
        check("postreset_v_total", v_total, 10);
        check("postreset_pix_xy", n_pixbad - s_pix, 0);
        check("frame_start_latency", n_latbad, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
